// File: rtl/mp3_fifo_pkg.sv
// Shared limits and width helpers for the MP3 bit reservoir FIFO.
package mp3_fifo_pkg;

    localparam int unsigned MAX_RD_LIMIT = 32;

    function automatic int unsigned rd_width(input int unsigned max_rd);
        return $clog2(max_rd + 1);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth_bytes);
        return $clog2(depth_bytes * 8 + 1);
    endfunction

    // Bytes a MAX_RD-bit read can touch when it starts at bit offset 7.
    function automatic int unsigned win_bytes(input int unsigned max_rd);
        return (max_rd + 14) / 8;
    endfunction

endpackage

// File: rtl/bit_window_extract.sv
// Pulls an nbits-wide field, MSB-first, out of a byte window starting at bit_off.
module bit_window_extract
    import mp3_fifo_pkg::*;
#(
    parameter int unsigned MAX_RD = 32,
    localparam int unsigned RW = rd_width(MAX_RD),
    localparam int unsigned WB = win_bytes(MAX_RD) * 8
) (
    input  logic [WB-1:0]     window,
    input  logic [2:0]        bit_off,
    input  logic [RW-1:0]     nbits,
    output logic [MAX_RD-1:0] field
);

    logic [WB-1:0] aligned;
    logic [WB-1:0] justified;

    always_comb begin
        aligned   = window << bit_off;
        justified = '0;
        if (nbits != '0 && 32'(nbits) <= MAX_RD) begin
            justified = aligned >> (WB - 32'(nbits));
        end
        field = justified[MAX_RD-1:0];
    end

endmodule

// File: rtl/bit_reservoir_fifo.sv
// Byte-in, variable-width-bit-out FIFO with exact bit count and byte-align discard.
module bit_reservoir_fifo
    import mp3_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 512,
    parameter int unsigned MAX_RD      = 32,
    localparam int unsigned RW = rd_width(MAX_RD),
    localparam int unsigned CW = cnt_width(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [7:0]        din,
    output logic              full,
    input  logic              rd_en,
    input  logic [RW-1:0]     rd_nbits,
    output logic              rd_ready,
    input  logic              align_en,
    output logic [MAX_RD-1:0] dout,
    output logic              dout_valid,
    output logic [CW-1:0]     bit_count,
    output logic              wr_drop,
    output logic              rd_reject
);

    localparam int unsigned AW   = $clog2(DEPTH_BYTES);
    localparam int unsigned PW   = AW + 3;
    localparam int unsigned NWIN = win_bytes(MAX_RD);

    logic [7:0]          mem_q [DEPTH_BYTES];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       bit_count_q, bit_count_d;
    logic [MAX_RD-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                wr_drop_q, wr_drop_d;
    logic                rd_reject_q, rd_reject_d;

    logic                wr_acc, rd_acc, align_acc;
    logic [AW-1:0]       rd_addr;
    logic [2:0]          bit_off, align_bits;
    logic [NWIN*8-1:0]   window;
    logic [MAX_RD-1:0]   field;

    assign rd_addr    = rd_ptr_q[PW-1:3];
    assign bit_off    = rd_ptr_q[2:0];
    assign align_bits = 3'(4'd8 - 4'(bit_off));

    // Threshold leaves a whole free byte even when the read byte is partially consumed.
    assign full     = bit_count_q > CW'(DEPTH_BYTES * 8 - 8);
    assign rd_ready = (rd_nbits != '0) && (rd_nbits <= RW'(MAX_RD))
                      && (CW'(rd_nbits) <= bit_count_q);

    always_comb begin
        window = '0;
        for (int i = 0; i < NWIN; i++) begin
            window[(NWIN-1-i)*8 +: 8] = mem_q[rd_addr + AW'(i)];
        end
    end

    bit_window_extract #(
        .MAX_RD (MAX_RD)
    ) u_extract (
        .window  (window),
        .bit_off (bit_off),
        .nbits   (rd_nbits),
        .field   (field)
    );

    always_comb begin
        wr_acc    = wr_en && !full && !flush;
        rd_acc    = rd_en && rd_ready && !flush;
        align_acc = align_en && !rd_en && !flush;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        wr_drop_d    = wr_en && full && !flush;
        rd_reject_d  = rd_en && !rd_ready && !flush;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(rd_nbits);
            dout_d   = field;
        end else if (align_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(align_bits);
        end

        bit_count_d = bit_count_q
                    + (wr_acc    ? CW'(8)          : '0)
                    - (rd_acc    ? CW'(rd_nbits)   : '0)
                    - (align_acc ? CW'(align_bits) : '0);

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            bit_count_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wr_drop_q    <= 1'b0;
            rd_reject_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            bit_count_q  <= bit_count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wr_drop_q    <= wr_drop_d;
            rd_reject_q  <= rd_reject_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_count  = bit_count_q;
    assign wr_drop    = wr_drop_q;
    assign rd_reject  = rd_reject_q;

endmodule
